// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - SAP-1 opcodes, one-hot T-states and control-word bit positions
package sap1_pkg;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [5:0] T1 = 6'b000001;
   localparam logic [5:0] T2 = 6'b000010;
   localparam logic [5:0] T3 = 6'b000100;
   localparam logic [5:0] T4 = 6'b001000;
   localparam logic [5:0] T5 = 6'b010000;
   localparam logic [5:0] T6 = 6'b100000;

   // Bit positions of the strobes when packed into one control word
   localparam int CW_CP = 0;
   localparam int CW_EP = 1;
   localparam int CW_LM = 2;
   localparam int CW_ER = 3;
   localparam int CW_LI = 4;
   localparam int CW_EI = 5;
   localparam int CW_LA = 6;
   localparam int CW_EA = 7;
   localparam int CW_SU = 8;
   localparam int CW_EU = 9;
   localparam int CW_LB = 10;
   localparam int CW_LO = 11;
   localparam int CW_W  = 12;

   function automatic logic is_known_op(input logic [3:0] op);
      return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
             (op == OP_OUT) || (op == OP_HLT);
   endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// rtl/sap1_ring_counter.sv - 6-position one-hot T-state ring with hold and early return to T1
module sap1_ring_counter
   import sap1_pkg::*;
(
   input  logic       clk_i,
   input  logic       clr_i,
   input  logic       hold_i,
   input  logic       jump_t1_i,
   output logic [5:0] t_state_o
);

   logic [5:0] ring_q;
   logic [5:0] ring_d;

   always_comb begin
      ring_d = ring_q;
      if (hold_i) begin
         ring_d = ring_q;
      end else if (jump_t1_i) begin
         ring_d = T1;
      end else begin
         ring_d = {ring_q[4:0], ring_q[5]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         ring_q <= T1;
      end else begin
         ring_q <= ring_d;
      end
   end

   assign t_state_o = ring_q;

endmodule

// File: rtl/sap1_ctrl_seq.sv
// rtl/sap1_ctrl_seq.sv - SAP-1 controller-sequencer: fetch/execute strobe decode and halt
// Optional early return to T1 after the last busy T-state: SAP1_VARIABLE_CYCLE_EN
module sap1_ctrl_seq
   import sap1_pkg::*;
(
   input  logic       clk_i,
   input  logic       clr_i,
   input  logic [3:0] opcode_i,
   output logic       cp_o,
   output logic       ep_o,
   output logic       lm_o,
   output logic       er_o,
   output logic       li_o,
   output logic       ei_o,
   output logic       la_o,
   output logic       ea_o,
   output logic       su_o,
   output logic       eu_o,
   output logic       lb_o,
   output logic       lo_o,
   output logic       halt_o,
   output logic [5:0] t_state_o
);

   logic [5:0]      ring;
   logic            halted_q;
   logic            halted_d;
   logic            hlt_now;
   logic            hold;
   logic            jump_t1;
   logic [CW_W-1:0] cw;

   sap1_ring_counter u_ring (
      .clk_i     (clk_i),
      .clr_i     (clr_i),
      .hold_i    (hold),
      .jump_t1_i (jump_t1),
      .t_state_o (ring)
   );

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end

   // HLT is seen during T4 (IR valid); the ring then freezes in T4 until clr
   always_comb begin
      hlt_now  = ring[3] && (opcode_i == OP_HLT) && !halted_q;
      halted_d = halted_q || hlt_now;
      hold     = halted_q || hlt_now;
`ifdef SAP1_VARIABLE_CYCLE_EN
      jump_t1  = (ring[4] && (opcode_i == OP_LDA)) ||
                 (ring[3] && (opcode_i == OP_OUT)) ||
                 (ring[2] && !is_known_op(opcode_i));
`else
      jump_t1  = 1'b0;
`endif
   end

   always_comb begin
      cw = '0;
      if (!clr_i && !halted_q) begin
         if (ring[0]) begin
            cw[CW_EP] = 1'b1;
            cw[CW_LM] = 1'b1;
         end
         if (ring[1]) begin
            cw[CW_CP] = 1'b1;
         end
         if (ring[2]) begin
            cw[CW_ER] = 1'b1;
            cw[CW_LI] = 1'b1;
         end
         if (ring[3]) begin
            if (opcode_i == OP_LDA || opcode_i == OP_ADD || opcode_i == OP_SUB) begin
               cw[CW_EI] = 1'b1;
               cw[CW_LM] = 1'b1;
            end else if (opcode_i == OP_OUT) begin
               cw[CW_EA] = 1'b1;
               cw[CW_LO] = 1'b1;
            end
         end
         if (ring[4]) begin
            if (opcode_i == OP_LDA) begin
               cw[CW_ER] = 1'b1;
               cw[CW_LA] = 1'b1;
            end else if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
               cw[CW_ER] = 1'b1;
               cw[CW_LB] = 1'b1;
            end
         end
         if (ring[5] && (opcode_i == OP_ADD || opcode_i == OP_SUB)) begin
            cw[CW_EU] = 1'b1;
            cw[CW_LA] = 1'b1;
            cw[CW_SU] = (opcode_i == OP_SUB);
         end
      end
   end

   assign cp_o      = cw[CW_CP];
   assign ep_o      = cw[CW_EP];
   assign lm_o      = cw[CW_LM];
   assign er_o      = cw[CW_ER];
   assign li_o      = cw[CW_LI];
   assign ei_o      = cw[CW_EI];
   assign la_o      = cw[CW_LA];
   assign ea_o      = cw[CW_EA];
   assign su_o      = cw[CW_SU];
   assign eu_o      = cw[CW_EU];
   assign lb_o      = cw[CW_LB];
   assign lo_o      = cw[CW_LO];
   assign halt_o    = halted_q && !clr_i;
   assign t_state_o = clr_i ? T1 : ring;

endmodule

// File: tb/tb_sap1_ctrl_seq.sv
// tb/tb_sap1_ctrl_seq.sv - self-checking bench for sap1_ctrl_seq with random instruction stream
module tb_sap1_ctrl_seq;
   import sap1_pkg::*;

   logic       clk = 1'b0;
   logic       clr;
   logic [3:0] opcode;
   logic       cp, ep, lm, er, li, ei, la, ea, su, eu, lb, lo, halt;
   logic [5:0] t_state;
   logic [CW_W-1:0] cw;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   sap1_ctrl_seq dut (
      .clk_i     (clk),
      .clr_i     (clr),
      .opcode_i  (opcode),
      .cp_o      (cp),
      .ep_o      (ep),
      .lm_o      (lm),
      .er_o      (er),
      .li_o      (li),
      .ei_o      (ei),
      .la_o      (la),
      .ea_o      (ea),
      .su_o      (su),
      .eu_o      (eu),
      .lb_o      (lb),
      .lo_o      (lo),
      .halt_o    (halt),
      .t_state_o (t_state)
   );

   always_comb begin
      cw        = '0;
      cw[CW_CP] = cp;
      cw[CW_EP] = ep;
      cw[CW_LM] = lm;
      cw[CW_ER] = er;
      cw[CW_LI] = li;
      cw[CW_EI] = ei;
      cw[CW_LA] = la;
      cw[CW_EA] = ea;
      cw[CW_SU] = su;
      cw[CW_EU] = eu;
      cw[CW_LB] = lb;
      cw[CW_LO] = lo;
   end

   // Reference: strobes for step s (0 = T1) of an instruction with opcode op
   function automatic logic [CW_W-1:0] exp_word(input logic [3:0] op, input int s);
      logic [CW_W-1:0] w;
      w = '0;
      case (s)
         0: begin w[CW_EP] = 1'b1; w[CW_LM] = 1'b1; end
         1: w[CW_CP] = 1'b1;
         2: begin w[CW_ER] = 1'b1; w[CW_LI] = 1'b1; end
         3: begin
            if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin
               w[CW_EI] = 1'b1; w[CW_LM] = 1'b1;
            end else if (op == 4'hE) begin
               w[CW_EA] = 1'b1; w[CW_LO] = 1'b1;
            end
         end
         4: begin
            if (op == 4'h0) begin
               w[CW_ER] = 1'b1; w[CW_LA] = 1'b1;
            end else if (op == 4'h1 || op == 4'h2) begin
               w[CW_ER] = 1'b1; w[CW_LB] = 1'b1;
            end
         end
         5: begin
            if (op == 4'h1 || op == 4'h2) begin
               w[CW_EU] = 1'b1; w[CW_LA] = 1'b1; w[CW_SU] = (op == 4'h2);
            end
         end
         default: w = '0;
      endcase
      return w;
   endfunction

   function automatic int instr_len(input logic [3:0] op);
`ifdef SAP1_VARIABLE_CYCLE_EN
      if (op == 4'h0) return 5;
      if (op == 4'hE) return 4;
      if (op == 4'h1 || op == 4'h2 || op == 4'hF) return 6;
      return 3;
`else
      return (op == op) ? 6 : 6;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_cycle(input string tag, input logic [CW_W-1:0] ew,
                              input logic [5:0] et, input logic eh);
      int nbus;
      nbus = int'(ep) + int'(er) + int'(ei) + int'(ea) + int'(eu);
      check({tag, "_cw"}, 32'(cw), 32'(ew));
      check({tag, "_t"}, 32'(t_state), 32'(et));
      check({tag, "_halt"}, 32'(halt), 32'(eh));
      check({tag, "_bus"}, 32'((nbus <= 1) && (!su || eu)), 32'd1);
   endtask

   task automatic run_instr(input logic [3:0] op);
      opcode = op;
      for (int s = 0; s < instr_len(op); s++) begin
         #1;
         check_cycle("instr", exp_word(op, s), 6'(6'd1 << s), 1'b0);
         cyc();
      end
   endtask

   initial begin
      logic [3:0] op;
      int         r;
      clr    = 1'b1;
      opcode = 4'h0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         #1;
         check_cycle("clr_hold", '0, 6'b000001, 1'b0);
         cyc();
      end
      clr = 1'b0;

      run_instr(4'h0);
      run_instr(4'h2);
      run_instr(4'h1);

      for (int n = 0; n < 40; n++) begin
         r = int'($urandom_range(0, 5));
         case (r)
            0: op = 4'h0;
            1: op = 4'h1;
            2: op = 4'h2;
            3: op = 4'hE;
            default: op = 4'($urandom_range(3, 13));
         endcase
         run_instr(op);
      end

      run_instr(4'hE);
      opcode = 4'hF;
      for (int s = 0; s < 4; s++) begin
         #1;
         check_cycle("hlt_run", exp_word(4'hF, s), 6'(6'd1 << s), 1'b0);
         cyc();
      end
      for (int i = 0; i < 10; i++) begin
         #1;
         check_cycle("halted", '0, 6'b001000, 1'b1);
         cyc();
      end
      clr = 1'b1;
      #1;
      check_cycle("halt_clr", '0, 6'b000001, 1'b0);
      cyc();
      clr = 1'b0;
      run_instr(4'h0);

      opcode = 4'h1;
      for (int s = 0; s < 5; s++) begin
         #1;
         check_cycle("add_part", exp_word(4'h1, s), 6'(6'd1 << s), 1'b0);
         if (s < 4) cyc();
      end
      clr = 1'b1;
      #1;
      check_cycle("mid_clr", '0, 6'b000001, 1'b0);
      cyc();
      clr = 1'b0;
      run_instr(4'h1);
      run_instr(4'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
